// File: rtl/riscv_bp_pkg.sv
// Shared types and helpers for the gshare-lite branch predictor.
// Counter encodings, FSM state type and the saturating counter step.
package riscv_bp_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

    // Next counter value from the counter that was originally predicted.
    function automatic logic [1:0] bp_sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == BP_ST) ? BP_ST : cnt + 2'b01;
        end
        return (cnt == BP_SNT) ? BP_SNT : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/riscv_bp_if.sv
// Fetch-side read and branch-unit update signals of the branch predictor.
// The predictor uses the slave modport; fetch/branch unit drive through master.
interface riscv_bp_if #(
    parameter int XLEN           = 32,
    parameter int BP_GLOBAL_BITS = 2
);

    logic                      if_stall;
    logic [XLEN-1:0]           if_nxt_pc;
    logic [1:0]                if_bp_predict;
    logic                      bp_ready;
    logic [XLEN-1:0]           ex_pc;
    logic [1:0]                bu_bp_predict;
    logic                      bu_bp_btaken;
    logic                      bu_bp_update;
    logic [BP_GLOBAL_BITS-1:0] bu_bp_history;

    modport master (
        output if_stall,
        output if_nxt_pc,
        input  if_bp_predict,
        input  bp_ready,
        output ex_pc,
        output bu_bp_predict,
        output bu_bp_btaken,
        output bu_bp_update,
        output bu_bp_history
    );

    modport slave (
        input  if_stall,
        input  if_nxt_pc,
        output if_bp_predict,
        output bp_ready,
        input  ex_pc,
        input  bu_bp_predict,
        input  bu_bp_btaken,
        input  bu_bp_update,
        input  bu_bp_history
    );

endinterface

// File: rtl/riscv_bp_ram.sv
// 1R1W synchronous counter table with registered, enable-gated read.
// A same-cycle write to the read address is forwarded (write-first).
module riscv_bp_ram #(
    parameter int AW = 12,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/riscv_bp.sv
// Global-history (gshare-lite) branch predictor: sweeps the table to weakly
// not-taken after reset, then serves 1-cycle predictions and branch updates.
module riscv_bp
    import riscv_bp_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BP_GLOBAL_BITS = 2,
    parameter int BP_LOCAL_BITS  = 10,
    parameter int HAS_RVC        = 0
) (
    input  logic       clk,
    input  logic       rstn,
    riscv_bp_if.slave  bp_if
);

    localparam int IDX    = BP_GLOBAL_BITS + BP_LOCAL_BITS;
    localparam int PC_LSB = (HAS_RVC != 0) ? 1 : 2;

    bp_state_t      state;
    logic [IDX-1:0] sweep;

    logic [IDX-1:0] rd_idx;
    logic [IDX-1:0] wr_idx;
    logic           ram_re;
    logic           ram_we;
    logic [IDX-1:0] ram_waddr;
    logic [1:0]     ram_wdata;
    logic [1:0]     ram_rdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= BP_INIT;
            sweep <= '0;
        end else begin
            case (state)
                BP_INIT: begin
                    sweep <= sweep + 1'b1;
                    if (sweep == {IDX{1'b1}}) begin
                        state <= BP_RUN;
                    end
                end
                default: state <= BP_RUN;
            endcase
        end
    end

    assign rd_idx = {bp_if.bu_bp_history, bp_if.if_nxt_pc[PC_LSB +: BP_LOCAL_BITS]};
    assign wr_idx = {bp_if.bu_bp_history, bp_if.ex_pc[PC_LSB +: BP_LOCAL_BITS]};

    // The sweep owns the single write port; branch updates during INIT are dropped.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_idx;
        ram_wdata = bp_sat_update(bp_if.bu_bp_predict, bp_if.bu_bp_btaken);
        if (state == BP_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = sweep;
            ram_wdata = BP_WNT;
        end else begin
            ram_we    = bp_if.bu_bp_update;
        end
    end

    // Reads keep running through INIT so the read register holds a swept value
    // by the time RUN starts, even if fetch stalls across the transition.
    assign ram_re = (state == BP_INIT) || !bp_if.if_stall;

    riscv_bp_ram #(
        .AW (IDX),
        .DW (2)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .raddr (rd_idx),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

    assign bp_if.if_bp_predict = (state == BP_RUN) ? ram_rdata : BP_WNT;
    assign bp_if.bp_ready      = (state == BP_RUN);

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp_if.if_nxt_pc[XLEN-1:PC_LSB+BP_LOCAL_BITS],
                              bp_if.if_nxt_pc[PC_LSB-1:0],
                              bp_if.ex_pc[XLEN-1:PC_LSB+BP_LOCAL_BITS],
                              bp_if.ex_pc[PC_LSB-1:0]};

endmodule

// File: tb/tb_riscv_bp.sv
// Directed and randomized checks of riscv_bp against a counter-table model
// indexed by {history, pc[11:2]} with 1-cycle, write-first, stall-holding reads.
module tb_riscv_bp;

    logic clk;
    logic rstn;

    riscv_bp_if #(.XLEN(32), .BP_GLOBAL_BITS(2)) bp_if ();

    riscv_bp #(
        .XLEN           (32),
        .BP_GLOBAL_BITS (2),
        .BP_LOCAL_BITS  (10),
        .HAS_RVC        (0)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .bp_if (bp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    int unsigned mdl [4096];
    logic [1:0]  exp_pred;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int entry(input logic [1:0] hist, input logic [31:0] pc);
        return int'(hist) * 1024 + int'((pc >> 2) & 32'h3ff);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4096; i++) mdl[i] = 1;
        exp_pred = 2'b01;
    endtask

    // One RUN-phase cycle: drive, update the model, then check the registered output.
    task automatic do_cycle(input bit stall, input logic [31:0] rpc, input bit upd,
                            input logic [31:0] wpc, input logic [1:0] pred, input bit taken,
                            input logic [1:0] hist, input string tag);
        int p;
        bp_if.if_stall      = stall;
        bp_if.if_nxt_pc     = rpc;
        bp_if.bu_bp_update  = upd;
        bp_if.ex_pc         = wpc;
        bp_if.bu_bp_predict = pred;
        bp_if.bu_bp_btaken  = taken;
        bp_if.bu_bp_history = hist;
        if (upd) begin
            p = int'(pred);
            if (taken) p = (p < 3) ? p + 1 : 3;
            else       p = (p > 0) ? p - 1 : 0;
            mdl[entry(hist, wpc)] = p;
        end
        if (!stall) exp_pred = 2'(mdl[entry(hist, rpc)]);
        @(posedge clk);
        #1;
        check(tag, bp_if.if_bp_predict, exp_pred);
    endtask

    // Counts edges until bp_ready, optionally firing random updates that must be dropped.
    task automatic wait_ready(input bit noisy, input string tag);
        int cnt;
        int pred_err;
        cnt      = 0;
        pred_err = 0;
        while (cnt < 5000) begin
            bp_if.if_stall      = 1'($urandom_range(0, 1));
            bp_if.if_nxt_pc     = $urandom;
            bp_if.ex_pc         = $urandom;
            bp_if.bu_bp_update  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            bp_if.bu_bp_predict = 2'($urandom_range(0, 3));
            bp_if.bu_bp_btaken  = 1'($urandom_range(0, 1));
            bp_if.bu_bp_history = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            cnt++;
            if (bp_if.bp_ready) break;
            if (bp_if.if_bp_predict !== 2'b01) pred_err++;
        end
        check({tag, "_ready_cycles"}, cnt, 4096);
        check({tag, "_init_pred"}, pred_err, 0);
        check({tag, "_first_run_pred"}, bp_if.if_bp_predict, 2'b01);
        bp_if.bu_bp_update = 1'b0;
        bp_if.if_stall     = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        rstn                = 1'b0;
        bp_if.if_stall      = 1'b0;
        bp_if.if_nxt_pc     = '0;
        bp_if.ex_pc         = '0;
        bp_if.bu_bp_update  = 1'b0;
        bp_if.bu_bp_predict = 2'b00;
        bp_if.bu_bp_btaken  = 1'b0;
        bp_if.bu_bp_history = 2'b00;

        // 1. reset and init sweep
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bp_if.bp_ready, 1'b0);
        check("rst_pred", bp_if.if_bp_predict, 2'b01);
        rstn = 1'b1;
        wait_ready(1'b0, "init");
        do_cycle(0, $urandom, 0, 0, 0, 0, 2'($urandom_range(0, 3)), "init_rand_read");

        // 2. saturation up at 0x200, down at 0x300
        do_cycle(0, 32'h0, 1, 32'h200, 2'b01, 1, 2'b00, "sat_up_w1");
        do_cycle(0, 32'h200, 0, 0, 0, 0, 2'b00, "sat_up_r1");
        check("sat_up_10", bp_if.if_bp_predict, 2'b10);
        do_cycle(0, 32'h0, 1, 32'h200, 2'b10, 1, 2'b00, "sat_up_w2");
        do_cycle(0, 32'h200, 0, 0, 0, 0, 2'b00, "sat_up_r2");
        check("sat_up_11", bp_if.if_bp_predict, 2'b11);
        do_cycle(0, 32'h0, 1, 32'h200, 2'b11, 1, 2'b00, "sat_up_w3");
        do_cycle(0, 32'h200, 0, 0, 0, 0, 2'b00, "sat_up_r3");
        check("sat_up_hold", bp_if.if_bp_predict, 2'b11);
        do_cycle(0, 32'h0, 1, 32'h300, 2'b01, 0, 2'b00, "sat_dn_w1");
        do_cycle(0, 32'h300, 0, 0, 0, 0, 2'b00, "sat_dn_r1");
        check("sat_dn_00", bp_if.if_bp_predict, 2'b00);
        do_cycle(0, 32'h0, 1, 32'h300, 2'b00, 0, 2'b00, "sat_dn_w2");
        do_cycle(0, 32'h300, 0, 0, 0, 0, 2'b00, "sat_dn_r2");
        check("sat_dn_hold", bp_if.if_bp_predict, 2'b00);

        // 3. same-cycle read/write collision
        do_cycle(0, 32'h344, 1, 32'h344, 2'b01, 1, 2'b00, "collide");
        check("collide_10", bp_if.if_bp_predict, 2'b10);

        // 4. stall holds output; writes during stall still land
        do_cycle(0, 32'h200, 0, 0, 0, 0, 2'b00, "stall_pre");
        check("stall_pre_11", bp_if.if_bp_predict, 2'b11);
        do_cycle(1, 32'h400, 1, 32'h200, 2'b11, 0, 2'b00, "stall_c1");
        check("stall_c1_held", bp_if.if_bp_predict, 2'b11);
        do_cycle(1, 32'h344, 1, 32'h400, 2'b10, 1, 2'b00, "stall_c2");
        check("stall_c2_held", bp_if.if_bp_predict, 2'b11);
        do_cycle(1, 32'h600, 0, 0, 0, 0, 2'b00, "stall_c3");
        check("stall_c3_held", bp_if.if_bp_predict, 2'b11);
        do_cycle(0, 32'h400, 0, 0, 0, 0, 2'b00, "stall_post_400");
        check("stall_post_400_11", bp_if.if_bp_predict, 2'b11);
        do_cycle(0, 32'h200, 0, 0, 0, 0, 2'b00, "stall_post_200");
        check("stall_post_200_10", bp_if.if_bp_predict, 2'b10);

        // 5. history separates entries for the same PC
        do_cycle(0, 32'h0, 1, 32'h500, 2'b01, 1, 2'b01, "hist_w01");
        do_cycle(0, 32'h0, 1, 32'h500, 2'b01, 0, 2'b10, "hist_w10");
        do_cycle(0, 32'h500, 0, 0, 0, 0, 2'b01, "hist_r01");
        check("hist_r01_10", bp_if.if_bp_predict, 2'b10);
        do_cycle(0, 32'h500, 0, 0, 0, 0, 2'b10, "hist_r10");
        check("hist_r10_00", bp_if.if_bp_predict, 2'b00);
        do_cycle(0, 32'h500, 0, 0, 0, 0, 2'b00, "hist_r00");
        check("hist_r00_01", bp_if.if_bp_predict, 2'b01);

        // random traffic over a small PC set to provoke collisions and stalls
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom_range(0, 3) == 0),
                     32'h1000 + 32'($urandom_range(0, 7)) * 4,
                     1'($urandom_range(0, 1)),
                     32'h1000 + 32'($urandom_range(0, 7)) * 4,
                     2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)),
                     "rand");
        end

        // 6. reset mid-run, noisy re-init, then every entry must read 01
        rstn = 1'b0;
        #1;
        check("midrst_ready", bp_if.bp_ready, 1'b0);
        check("midrst_pred", bp_if.if_bp_predict, 2'b01);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        wait_ready(1'b1, "reinit");
        for (int h = 0; h < 4; h++) begin
            for (int f = 0; f < 1024; f++) begin
                do_cycle(0, 32'(f) << 2, 0, 0, 0, 0, 2'(h), "reinit_sweep");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
